ccip_rd_engine: RTL and testbench

- CCI-P memory read engine; inbound counterpart of the AFU's c1 write path.
- Fetches num_lines consecutive cache lines starting at src_addr over channel c0.
- Buffers returned lines in an internal FIFO and streams them to AFU logic over a valid/ready interface.
- Sits between the CSR block (which supplies src_addr, num_lines and start) and the compute datapath.

---
 rtl/ccip_rd_engine_if.sv | 46 ++++
 rtl/ccip_rd_engine.sv | 196 +++++++++++++++++++
 tb/tb_ccip_rd_engine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccip_rd_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : ccip_rd_engine_if
// Description : Bus bundle for the CCI-P read engine. Carries the c0 read
//               request channel (tx), the c0 response channel (rx) and the
//               valid/ready line stream towards the compute datapath.
//               master : the read engine
//               slave  : CCI-P shim / consumer side
// Ports       : c0TxAlmFull, c0_tx_valid/addr/mdata,
//               c0_rx_rspValid/resp_type/mdata/data,
//               out_valid, out_ready, out_data, out_idx
// Revision    : 1.0 - initial release
// ============================================================================
interface ccip_rd_engine_if #(
    parameter int MDATA_W = 16
);
    logic               c0TxAlmFull;
    logic               c0_tx_valid;
    logic [41:0]        c0_tx_addr;
    logic [MDATA_W-1:0] c0_tx_mdata;
    logic               c0_rx_rspValid;
    logic [3:0]         c0_rx_resp_type;
    logic [MDATA_W-1:0] c0_rx_mdata;
    logic [511:0]       c0_rx_data;
    logic               out_valid;
    logic               out_ready;
    logic [511:0]       out_data;
    logic [31:0]        out_idx;

    modport master (
        input  c0TxAlmFull,
        output c0_tx_valid, c0_tx_addr, c0_tx_mdata,
        input  c0_rx_rspValid, c0_rx_resp_type, c0_rx_mdata, c0_rx_data,
        output out_valid, out_data, out_idx,
        input  out_ready
    );

    modport slave (
        output c0TxAlmFull,
        input  c0_tx_valid, c0_tx_addr, c0_tx_mdata,
        output c0_rx_rspValid, c0_rx_resp_type, c0_rx_mdata, c0_rx_data,
        input  out_valid, out_data, out_idx,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ccip_rd_engine.sv
`default_nettype none
// ============================================================================
// Module      : ccip_rd_engine
// Description : CCI-P c0 memory read engine. Reads num_lines consecutive
//               cache lines from src_addr, buffers responses in a FIFO and
//               streams them out (arrival order) with their line index.
//               Requests in flight are credit limited to FIFO_DEPTH so the
//               response buffer can never overflow.
// Ports       : clk, reset_n (async, active low)
//               start, src_addr, num_lines   - job control from CSRs
//               busy, done                   - job status
//               bus (master)                 - c0 tx/rx and line stream
// Revision    : 1.0 - initial release
// ============================================================================
module ccip_rd_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int MDATA_W    = 16
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          start,
    input  wire logic [41:0]   src_addr,
    input  wire logic [31:0]   num_lines,
    output logic               busy,
    output logic               done,
    ccip_rd_engine_if.master   bus
);
    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_LCNT_W  = MDATA_W + 1;
    localparam int c_ENTRY_W = 512 + 32;
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    // Line index is carried entirely in the tag, so a job is capped at
    // 2^MDATA_W lines; larger requests are truncated to that count.
    localparam logic [c_LCNT_W-1:0] c_MAX_LINES = {1'b1, {MDATA_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [41:0]           r_base;
    logic [c_LCNT_W-1:0]   r_num;
    logic [c_LCNT_W-1:0]   r_req_cnt;
    logic [c_LCNT_W-1:0]   r_rsp_cnt;
    logic [c_CNT_W-1:0]    r_in_flight;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_tx_valid;
    logic [41:0]           r_tx_addr;
    logic [MDATA_W-1:0]    r_tx_mdata;

    logic                  w_start_acc;
    logic [c_LCNT_W-1:0]   w_num_clamp;
    logic                  w_issue;
    logic                  w_rsp_acc;
    logic                  w_pop;
    logic                  w_full;
    logic [c_CNT_W-1:0]    w_count_nxt;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_num_clamp = (num_lines > 32'(c_MAX_LINES)) ? c_MAX_LINES
                                                         : num_lines[c_LCNT_W-1:0];
    assign w_issue     = (r_state == ST_ISSUE) && (r_req_cnt < r_num) &&
                         !bus.c0TxAlmFull && (r_in_flight < c_DEPTH);
    assign w_rsp_acc   = bus.c0_rx_rspValid && (bus.c0_rx_resp_type == 4'h0) &&
                         ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_pop       = r_out_valid && bus.out_ready;
    assign w_full      = (r_count == c_DEPTH);
    assign w_count_nxt = r_count + c_CNT_W'(w_rsp_acc) - c_CNT_W'(w_pop);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = (w_num_clamp == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue && ((r_req_cnt + c_LCNT_W'(1)) == r_num)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_rsp_cnt == r_num) && (r_count == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, request port and FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_base      <= '0;
            r_num       <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_in_flight <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_mdata  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Status flags are registered copies of the next state so they
            // line up exactly with the state register.
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);

            if (w_start_acc) begin
                r_base      <= src_addr;
                r_num       <= w_num_clamp;
                r_req_cnt   <= '0;
                r_rsp_cnt   <= '0;
                r_in_flight <= '0;
            end else begin
                if (w_issue) begin
                    r_req_cnt <= r_req_cnt + c_LCNT_W'(1);
                end
                if (w_rsp_acc) begin
                    r_rsp_cnt <= r_rsp_cnt + c_LCNT_W'(1);
                end
                // Credit returns on pop, not on response arrival, so that
                // buffered-but-unconsumed lines still hold their slot.
                case ({w_issue, w_pop})
                    2'b10:   r_in_flight <= r_in_flight + c_CNT_W'(1);
                    2'b01:   r_in_flight <= r_in_flight - c_CNT_W'(1);
                    default: r_in_flight <= r_in_flight;
                endcase
            end

            r_tx_valid <= w_issue;
            if (w_issue) begin
                r_tx_addr  <= r_base + 42'(r_req_cnt);
                r_tx_mdata <= r_req_cnt[MDATA_W-1:0];
            end

            if (w_rsp_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
        end
    end

    // Storage array carries no reset; contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_rsp_acc) begin
            r_mem[r_wr_ptr] <= {bus.c0_rx_data, 32'(bus.c0_rx_mdata)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_rsp_acc) begin
            assert (!w_full);
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.c0_tx_valid = r_tx_valid;
    assign bus.c0_tx_addr  = r_tx_addr;
    assign bus.c0_tx_mdata = r_tx_mdata;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_mem[r_rd_ptr][c_ENTRY_W-1:32];
    assign bus.out_idx     = r_mem[r_rd_ptr][31:0];

endmodule
`default_nettype wire

// File: tb/tb_ccip_rd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccip_rd_engine
// Description : Self-checking bench for ccip_rd_engine (FIFO_DEPTH = 4).
//               Expected output lines are queued when a response is driven
//               and compared when the engine delivers a line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccip_rd_engine;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start;
    logic [41:0] src_addr;
    logic [31:0] num_lines;
    logic        busy;
    logic        done;

    ccip_rd_engine_if #(.MDATA_W(16)) bus ();

    ccip_rd_engine #(.FIFO_DEPTH(DEPTH), .MDATA_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .num_lines (num_lines),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           pops = 0;
    int           done_cnt = 0;
    logic [31:0]  salt = 32'h0;
    logic [41:0]  req_addr_q[$];
    logic [15:0]  req_tag_q[$];
    logic [31:0]  exp_idx_q[$];
    logic [511:0] exp_data_q[$];
    logic [31:0]  e_idx;
    logic [511:0] e_data;

    function automatic logic [511:0] mk_data(input logic [15:0] tag, input logic [31:0] s);
        return {16{s ^ {16'h0, tag}}};
    endfunction

    // Monitor: records requests, counts done pulses, checks delivered lines.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.c0_tx_valid) begin
                req_addr_q.push_back(bus.c0_tx_addr);
                req_tag_q.push_back(bus.c0_tx_mdata);
            end
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                total++;
                if (exp_idx_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected: got idx=%0d, required no line", bus.out_idx);
                end else begin
                    e_idx  = exp_idx_q.pop_front();
                    e_data = exp_data_q.pop_front();
                    if (bus.out_idx !== e_idx || bus.out_data !== e_data) begin
                        bad++;
                        $display("FAIL out_line: got idx=%0d data[31:0]=%h, required idx=%0d data[31:0]=%h",
                                 bus.out_idx, bus.out_data[31:0], e_idx, e_data[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [41:0] a, input logic [31:0] n, input logic [31:0] s);
        req_addr_q.delete();
        req_tag_q.delete();
        pops = 0;
        salt = s;
        start = 1'b1;
        src_addr = a;
        num_lines = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] tag, input logic [3:0] typ, input bit expect_line);
        bus.c0_rx_rspValid  = 1'b1;
        bus.c0_rx_resp_type = typ;
        bus.c0_rx_mdata     = tag;
        bus.c0_rx_data      = mk_data(tag, salt);
        if (expect_line) begin
            exp_idx_q.push_back({16'h0, tag});
            exp_data_q.push_back(mk_data(tag, salt));
        end
        tick();
        bus.c0_rx_rspValid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int c = 0;
        while (req_tag_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        total++;
        if (req_tag_q.size() < n) begin
            bad++;
            $display("FAIL wait_reqs: got %0d requests, required %0d", req_tag_q.size(), n);
        end
    endtask

    // Answers issued requests in issue order, from request number k0 up to n.
    task automatic service(input int k0, input int n);
        int k = k0;
        int c = 0;
        while (k < n && c < 2000) begin
            if (req_tag_q.size() > k) begin
                send_rsp(req_tag_q[k], 4'h0, 1'b1);
                k++;
            end else begin
                tick();
                c++;
            end
        end
        total++;
        if (k < n) begin
            bad++;
            $display("FAIL service: answered %0d requests, required %0d", k, n);
        end
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        int d0 = done_cnt;
        while (!done && c < 1000) begin
            tick();
            c++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: got done=%b, required 1", done);
        end else begin
            total++;
            if (pops != n) begin
                bad++;
                $display("FAIL pops_at_done: got %0d, required %0d", pops, n);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_with_done: got %b, required 1", busy);
            end
            tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_after_done: got %b, required 0", busy);
            end
            repeat (3) tick();
            total++;
            if (done_cnt - d0 != 1) begin
                bad++;
                $display("FAIL done_pulses: got %0d, required 1", done_cnt - d0);
            end
        end
        total++;
        if (exp_idx_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_lines: got %0d undelivered, required 0", exp_idx_q.size());
        end
    endtask

    task automatic check_reqs(input logic [41:0] base, input int n);
        total++;
        if (req_tag_q.size() != n) begin
            bad++;
            $display("FAIL req_count: got %0d, required %0d", req_tag_q.size(), n);
        end
        for (int k = 0; k < req_tag_q.size(); k++) begin
            total++;
            if (req_addr_q[k] !== base + 42'(k) || req_tag_q[k] !== 16'(k)) begin
                bad++;
                $display("FAIL req_%0d: got addr=%h tag=%0d, required addr=%h tag=%0d",
                         k, req_addr_q[k], req_tag_q[k], base + 42'(k), k);
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        src_addr = '0;
        num_lines = '0;
        bus.c0TxAlmFull = 1'b0;
        bus.c0_rx_rspValid = 1'b0;
        bus.c0_rx_resp_type = 4'h0;
        bus.c0_rx_mdata = '0;
        bus.c0_rx_data = '0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy, done, bus.c0_tx_valid, bus.out_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got busy/done/tx_valid/out_valid=%b, required 0000",
                     {busy, done, bus.c0_tx_valid, bus.out_valid});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if ({busy, done, bus.c0_tx_valid, bus.out_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b, required 0000",
                     {busy, done, bus.c0_tx_valid, bus.out_valid});
        end
    endtask

    task automatic test_in_order();
        bus.out_ready = 1'b1;
        start_job(42'h1000, 32'd4, 32'h1111_0000);
        wait_reqs(4, 50);
        for (int k = 0; k < 4; k++) send_rsp(16'(k), 4'h0, 1'b1);
        wait_done(4);
        check_reqs(42'h1000, 4);
    endtask

    task automatic test_out_of_order();
        bus.out_ready = 1'b1;
        start_job(42'h2000, 32'd4, 32'h2222_0000);
        wait_reqs(4, 50);
        send_rsp(16'd2, 4'h0, 1'b1);
        send_rsp(16'd0, 4'h0, 1'b1);
        send_rsp(16'd3, 4'h0, 1'b1);
        send_rsp(16'd1, 4'h0, 1'b1);
        wait_done(4);
        check_reqs(42'h2000, 4);
    endtask

    task automatic test_credit();
        logic [31:0]  h_idx;
        logic [511:0] h_data;
        bus.out_ready = 1'b0;
        start_job(42'h3000, 32'd10, 32'h3333_0000);
        repeat (20) tick();
        total++;
        if (req_tag_q.size() != DEPTH) begin
            bad++;
            $display("FAIL credit_limit: got %0d requests, required %0d", req_tag_q.size(), DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) send_rsp(16'(k), 4'h0, 1'b1);
        repeat (4) tick();
        h_idx  = bus.out_idx;
        h_data = bus.out_data;
        repeat (10) tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== h_idx || bus.out_data !== h_data || h_idx !== 32'd0) begin
            bad++;
            $display("FAIL stall_stable: got valid=%b idx=%0d (earlier %0d), required valid=1 idx=0 unchanged",
                     bus.out_valid, bus.out_idx, h_idx);
        end
        total++;
        if (req_tag_q.size() != DEPTH) begin
            bad++;
            $display("FAIL credit_hold: got %0d requests, required %0d", req_tag_q.size(), DEPTH);
        end
        bus.out_ready = 1'b1;
        service(DEPTH, 10);
        wait_done(10);
        check_reqs(42'h3000, 10);
    endtask

    task automatic test_almfull();
        bus.out_ready = 1'b1;
        start_job(42'h4000, 32'd12, 32'h4444_0000);
        tick();
        bus.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (bus.c0_tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL almfull_window_%0d: got tx_valid=%b, required 0", i, bus.c0_tx_valid);
            end
        end
        bus.c0TxAlmFull = 1'b0;
        tick();
        service(0, 12);
        wait_done(12);
        check_reqs(42'h4000, 12);
    endtask

    task automatic test_zero_and_stray();
        int d0;
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        start_job(42'h5000, 32'd0, 32'h5555_0000);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: got done=%b busy=%b, required 1 1", done, busy);
        end
        tick();
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (5) tick();
        total++;
        if (req_tag_q.size() != 0 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL zero_job: got %0d requests %0d done pulses, required 0 and 1",
                     req_tag_q.size(), done_cnt - d0);
        end
        start_job(42'h5100, 32'd2, 32'h5A5A_0000);
        wait_reqs(2, 50);
        send_rsp(16'd0, 4'h1, 1'b0);
        repeat (3) tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_ignored: got out_valid=%b, required 0", bus.out_valid);
        end
        send_rsp(16'd0, 4'h0, 1'b1);
        send_rsp(16'd1, 4'h0, 1'b1);
        wait_done(2);
        check_reqs(42'h5100, 2);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        bus.out_ready = 1'b1;
        start_job(42'h6000, 32'd8, 32'h6666_0000);
        while (req_tag_q.size() < 3 && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (req_tag_q.size() != 3 || {busy, done, bus.c0_tx_valid, bus.out_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid: got %0d requests, busy/done/tx_valid/out_valid=%b, required 3 and 0000",
                     req_tag_q.size(), {busy, done, bus.c0_tx_valid, bus.out_valid});
        end
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) send_rsp(16'(k), 4'h0, 1'b0);
        repeat (4) tick();
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL late_rsp_ignored: got out_valid=%b busy=%b, required 0 0", bus.out_valid, busy);
        end
        start_job(42'h7000, 32'd3, 32'h7777_0000);
        service(0, 3);
        wait_done(3);
        check_reqs(42'h7000, 3);
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_credit();
        test_almfull();
        test_zero_and_stray();
        test_reset_mid();
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
